// File: rtl/spart_driver.sv
// SPART bus initiator: programs the baud divisor, then echoes every received
// byte back through the transmitter and interleaves locally injected bytes.
module spart_driver #(
  parameter int CLK_HZ     = 50000000,
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  br_cfg,
  inout  wire  [7:0]  databus,
  output logic [1:0]  ioaddr,
  output logic        iocs,
  output logic        iorw,
  input  logic        rda,
  input  logic        tbr,
  input  logic        send_valid,
  input  logic [7:0]  send_data,
  output logic        send_ready,
  output logic [7:0]  rx_byte,
  output logic [15:0] byte_cnt,
  output logic        cfg_done
);

  localparam logic [15:0] DIV_4800  = 16'(CLK_HZ / (OVERSAMPLE * 4800)  - 1);
  localparam logic [15:0] DIV_9600  = 16'(CLK_HZ / (OVERSAMPLE * 9600)  - 1);
  localparam logic [15:0] DIV_19200 = 16'(CLK_HZ / (OVERSAMPLE * 19200) - 1);
  localparam logic [15:0] DIV_38400 = 16'(CLK_HZ / (OVERSAMPLE * 38400) - 1);

  localparam logic [1:0] A_DATA   = 2'b00;
  localparam logic [1:0] A_STATUS = 2'b01;
  localparam logic [1:0] A_DIV_LO = 2'b10;
  localparam logic [1:0] A_DIV_HI = 2'b11;

  typedef enum logic [2:0] {
    CFG_LO, CFG_HI, POLL_RX, READ_RX, POLL_TX, WRITE_TX, IDLE
  } state_t;

  state_t      state, next_state;
  logic [1:0]  cfg_q;
  logic [7:0]  wr_byte;
  logic [15:0] div;
  logic [7:0]  dout;
  logic        st_rda, st_tbr, cfg_chg;
  logic        nx_iocs, nx_iorw;
  logic [1:0]  nx_ioaddr;

  always_comb begin
    case (cfg_q)
      2'b00:   div = DIV_4800;
      2'b01:   div = DIV_9600;
      2'b10:   div = DIV_19200;
      default: div = DIV_38400;
    endcase
  end

  // Status is whatever the bus returns, qualified by the direct strobes.
  assign st_rda  = databus[0] & rda;
  assign st_tbr  = databus[1] & tbr;
  assign cfg_chg = (br_cfg != cfg_q);

  always_comb begin
    dout = wr_byte;
    if (state == CFG_LO)      dout = div[7:0];
    else if (state == CFG_HI) dout = div[15:8];
  end

  assign databus = (iocs && !iorw) ? dout : 8'bz;

  // send_ready must coincide with the POLL_RX status read that grants it,
  // so it is decoded rather than registered.
  always_comb begin
    next_state = state;
    send_ready = 1'b0;
    case (state)
      CFG_LO:   if (iocs) next_state = CFG_HI;  // first post-reset cycle has iocs=0
      CFG_HI:   next_state = POLL_RX;
      POLL_RX: begin
        if (cfg_chg)         next_state = CFG_LO;
        else if (st_rda)     next_state = READ_RX;
        else if (send_valid) begin
          send_ready = 1'b1;
          next_state = POLL_TX;
        end
      end
      READ_RX:  next_state = POLL_TX;
      POLL_TX:  if (st_tbr) next_state = WRITE_TX;
      WRITE_TX: next_state = IDLE;
      IDLE:     next_state = POLL_RX;
      default:  next_state = CFG_LO;
    endcase
  end

  always_comb begin
    nx_iocs   = (next_state != IDLE);
    nx_iorw   = 1'b1;
    nx_ioaddr = A_STATUS;
    case (next_state)
      CFG_LO:   begin nx_iorw = 1'b0; nx_ioaddr = A_DIV_LO; end
      CFG_HI:   begin nx_iorw = 1'b0; nx_ioaddr = A_DIV_HI; end
      READ_RX:  nx_ioaddr = A_DATA;
      WRITE_TX: begin nx_iorw = 1'b0; nx_ioaddr = A_DATA; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CFG_LO;
      iocs     <= 1'b0;
      iorw     <= 1'b1;
      ioaddr   <= A_DATA;
      rx_byte  <= 8'h00;
      byte_cnt <= 16'h0000;
      cfg_done <= 1'b0;
      cfg_q    <= br_cfg;
      wr_byte  <= 8'h00;
    end else begin
      state  <= next_state;
      iocs   <= nx_iocs;
      iorw   <= nx_iorw;
      ioaddr <= nx_ioaddr;
      case (state)
        CFG_HI: cfg_done <= 1'b1;
        POLL_RX: begin
          if (cfg_chg) begin
            cfg_q    <= br_cfg;
            cfg_done <= 1'b0;
          end else if (send_ready) begin
            wr_byte <= send_data;
          end
        end
        READ_RX: begin
          rx_byte <= databus;
          wr_byte <= databus;
        end
        WRITE_TX: byte_cnt <= byte_cnt + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: bus-level SPART model, divisor table, directed corner
// sequences and a randomized echo/inject run checked against a stream model.
module tb_spart_driver;

  logic        clk, rst;
  logic [1:0]  br_cfg;
  wire  [7:0]  databus;
  logic [1:0]  ioaddr;
  logic        iocs, iorw;
  logic        rda, tbr;
  logic        send_valid;
  logic [7:0]  send_data;
  logic        send_ready;
  logic [7:0]  rx_byte;
  logic [15:0] byte_cnt;
  logic        cfg_done;

  spart_driver dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .databus(databus), .ioaddr(ioaddr),
    .iocs(iocs), .iorw(iorw), .rda(rda), .tbr(tbr), .send_valid(send_valid),
    .send_data(send_data), .send_ready(send_ready), .rx_byte(rx_byte),
    .byte_cnt(byte_cnt), .cfg_done(cfg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // SPART peripheral model
  logic [7:0] rxq[$];
  logic [7:0] txlog[$];
  logic [7:0] rx_head;
  logic [7:0] bus_rd;

  assign bus_rd  = (ioaddr == 2'b01) ? {6'b0, tbr, rda} : rx_head;
  assign databus = (iocs && iorw) ? bus_rd : 8'bz;

  function automatic void upd();
    rda     = (rxq.size() != 0);
    rx_head = (rxq.size() != 0) ? rxq[0] : 8'h00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rxq.push_back(b);
    upd();
  endtask

  // Bus monitor: snapshot mid-cycle, act just after the closing edge.
  initial begin
    logic s_rst, s_cs, s_rw;
    logic [1:0] s_addr;
    logic [7:0] s_dat;
    forever begin
      @(negedge clk);
      s_rst = rst; s_cs = iocs; s_rw = iorw; s_addr = ioaddr; s_dat = databus;
      @(posedge clk);
      #1;
      if (!s_rst && s_cs && s_addr == 2'b00) begin
        if (!s_rw) txlog.push_back(s_dat);
        else if (rxq.size() != 0) begin
          void'(rxq.pop_front());
          upd();
        end
      end
    end
  end

  typedef struct {
    logic [1:0] cfg;
    logic [7:0] lo;
    logic [7:0] hi;
  } cfg_vec_t;

  cfg_vec_t tbl[4];

  // Reset, then check the two divisor writes and the start of polling.
  task automatic do_config(input cfg_vec_t v, input bit chk_reset);
    rst = 1'b1; br_cfg = v.cfg; send_valid = 1'b0;
    rxq.delete(); upd();
    tick(); tick();
    if (chk_reset) begin
      chk("rst_iocs", iocs, 0);
      chk("rst_iorw", iorw, 1);
      chk("rst_ioaddr", ioaddr, 0);
      chk("rst_cnt", byte_cnt, 0);
      chk("rst_rxbyte", rx_byte, 0);
      chk("rst_cfgdone", cfg_done, 0);
      chk("rst_ready", send_ready, 0);
    end
    rst = 1'b0;
    tick();
    chk("cfg_lo_bus", {iocs, iorw, ioaddr}, {1'b1, 1'b0, 2'b10});
    chk("cfg_lo_data", databus, v.lo);
    tick();
    chk("cfg_hi_addr", ioaddr, 2'b11);
    chk("cfg_hi_data", databus, v.hi);
    tick();
    chk("poll_bus", {iocs, iorw, ioaddr}, {1'b1, 1'b1, 2'b01});
    chk("poll_cfgdone", cfg_done, 1);
  endtask

  initial begin
    logic [7:0] exp_rx[$];
    logic [7:0] exp_loc[$];
    logic [7:0] got_rx[$];
    logic [7:0] got_loc[$];
    logic [7:0] b;
    int ok, n, errs;
    bit acc, done;

    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_rx[$];
    logic [7:0] exp_loc[$];
    logic [7:0] got_rx[$];
    logic [7:0] got_loc[$];
    logic [7:0] b;
    int ok, n, errs;
    bit acc, done;

    tbl[0] = '{2'b00, 8'h8A, 8'h02};
    tbl[1] = '{2'b01, 8'h44, 8'h01};
    tbl[2] = '{2'b10, 8'hA1, 8'h00};
    tbl[3] = '{2'b11, 8'h50, 8'h00};

    rst = 1'b1; br_cfg = 2'b01; tbr = 1'b0; send_valid = 1'b0; send_data = 8'h00;
    upd();

    for (int i = 0; i < 4; i++) do_config(tbl[i], i == 0);

    // Echo of one received byte
    do_config(tbl[1], 0);
    tbr = 1'b1;
    push_rx(8'h5A);
    tick(); chk("echo_read_bus", {iocs, iorw, ioaddr}, {1'b1, 1'b1, 2'b00});
    tick(); chk("echo_poll_tx", ioaddr, 2'b01);
            chk("echo_rxbyte", rx_byte, 8'h5A);
    tick(); chk("echo_write_bus", {iocs, iorw, ioaddr}, {1'b1, 1'b0, 2'b00});
            chk("echo_write_data", databus, 8'h5A);
    tick(); chk("echo_idle", iocs, 0);
            chk("echo_cnt", byte_cnt, 1);
    tick(); chk("echo_back_poll", {iocs, iorw, ioaddr}, {1'b1, 1'b1, 2'b01});

    // Transmitter busy: hold in POLL_TX
    tbr = 1'b0;
    push_rx(8'h11);
    tick(); tick();
    n = txlog.size();
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!(iocs && iorw && ioaddr == 2'b01)) ok = 0;
    end
    chk("hold_poll_tx", ok, 1);
    chk("hold_no_write", txlog.size(), n);
    tbr = 1'b1;
    tick(); chk("hold_write_data", {iorw, databus}, {1'b0, 8'h11});
    tick(); tick();
    chk("hold_cnt", byte_cnt, 2);

    // rda and local send together: rx wins, send follows
    push_rx(8'h77);
    send_valid = 1'b1; send_data = 8'hC3;
    #1;
    chk("prio_no_ready", send_ready, 0);
    tick(); tick();
    tick(); chk("prio_echo_first", databus, 8'h77);
    tick(); tick();
    #1;
    chk("prio_ready", send_ready, 1);
    tick(); send_valid = 1'b0; send_data = 8'h00;
    #1;
    chk("prio_ready_drop", send_ready, 0);
    tick(); chk("prio_local_write", {iorw, ioaddr, databus}, {1'b0, 2'b00, 8'hC3});
    tick(); tick();

    // br_cfg change during POLL_TX
    tbr = 1'b0;
    push_rx(8'h3C);
    tick(); tick();
    br_cfg = 2'b11;
    tick();
    tbr = 1'b1;
    tick(); chk("recfg_byte_done", databus, 8'h3C);
            chk("recfg_done_hold", cfg_done, 1);
    tick(); tick();
    tick(); chk("recfg_lo", {ioaddr, databus}, {2'b10, 8'h50});
            chk("recfg_done_lo", cfg_done, 0);
    tick(); chk("recfg_hi", {ioaddr, databus}, {2'b11, 8'h00});
            chk("recfg_done_hi", cfg_done, 0);
    tick(); chk("recfg_done_set", cfg_done, 1);

    // Reset during READ_RX
    push_rx(8'h99);
    tick(); chk("mid_read_bus", {iocs, iorw, ioaddr}, {1'b1, 1'b1, 2'b00});
    rst = 1'b1; rxq.delete(); upd();
    tick();
    chk("mid_rst_iocs", iocs, 0);
    chk("mid_rst_cnt", byte_cnt, 0);
    chk("mid_rst_rxbyte", rx_byte, 0);
    rst = 1'b0;
    tick(); chk("mid_rst_cfg_lo", {iocs, iorw, ioaddr, databus}, {1'b1, 1'b0, 2'b10, 8'h50});
    tick(); tick();

    // byte_cnt wrap
    force dut.byte_cnt = 16'hFFFF;
    #1;
    release dut.byte_cnt;
    push_rx(8'h42);
    tick(); tick(); tick(); tick();
    chk("wrap_cnt", byte_cnt, 16'h0000);
    tick();

    // Randomized echo/inject run
    do_config(tbl[$urandom_range(0, 3)], 0);
    txlog.delete();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      acc = send_valid && send_ready;
      tick();
      if (acc) begin
        exp_loc.push_back(send_data);
        send_valid = 1'b0;
      end else if (!send_valid && $urandom_range(0, 15) == 0) begin
        send_valid = 1'b1;
        send_data  = 8'($urandom_range(128, 255));
      end else if (!send_valid) begin
        send_data = 8'($urandom_range(0, 255));
      end
      if (rxq.size() < 2 && $urandom_range(0, 9) == 0) begin
        b = 8'($urandom_range(0, 127));
        exp_rx.push_back(b);
        push_rx(b);
      end
      tbr = ($urandom_range(0, 3) != 0);
    end
    tbr = 1'b1;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      acc = send_valid && send_ready;
      tick();
      if (acc) begin
        exp_loc.push_back(send_data);
        send_valid = 1'b0;
      end
      if (rxq.size() == 0 && !send_valid &&
          txlog.size() == exp_rx.size() + exp_loc.size()) done = 1;
    end
    chk("rand_drained", done, 1);
    foreach (txlog[i]) begin
      if (txlog[i][7]) got_loc.push_back(txlog[i]);
      else             got_rx.push_back(txlog[i]);
    end
    chk("rand_rx_count", got_rx.size(), exp_rx.size());
    chk("rand_loc_count", got_loc.size(), exp_loc.size());
    errs = 0;
    foreach (exp_rx[i])  if (i < got_rx.size()  && got_rx[i]  !== exp_rx[i])  errs++;
    foreach (exp_loc[i]) if (i < got_loc.size() && got_loc[i] !== exp_loc[i]) errs++;
    chk("rand_stream_order", errs, 0);
    chk("rand_byte_cnt", byte_cnt, 16'(exp_rx.size() + exp_loc.size()));
    if (exp_rx.size() != 0) chk("rand_last_rx", rx_byte, exp_rx[exp_rx.size() - 1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
